// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg -- shared definitions for the data-memory port arbiter.
//   arb_state_e  : arbiter FSM states (RR = round robin, LOCK_B = port B burst lock)
//   PORT_A/PORT_B: bit positions of each port inside request/grant vectors
//   port_onehot(): one-hot grant vector for a single port index
package dmem_arb_pkg;

  typedef enum logic {
    RR     = 1'b0,
    LOCK_B = 1'b1
  } arb_state_e;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// dmem_arb_rr_pick -- combinational two-way round-robin chooser.
// Ports:
//   req  [1:0] : request vector, bit PORT_A / PORT_B
//   last       : port index that won the most recent accepted transaction
//   gnt  [1:0] : one-hot grant (all zero when nobody requests)
module dmem_arb_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a conflict the port that did not win last time goes first.
    if (req == 2'b11) begin
      gnt = port_onehot(~last);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter -- shares one single-port synchronous RAM between the CPU
// data path (port A) and the UART programmer (port B).
// Optional feature macro: DMEM_ARB_STATS_EN adds oConflictCount.
// Ports:
//   iCpuClock, iCpuReset               : clock, synchronous active-high reset
//   iReqA/iWeA/iAddrA/iWdataA          : port A request, write enable, address, data
//   oGntA/oRvalidA/oRdataA             : port A grant, read valid, read data
//   iReqB/iWeB/iAddrB/iWdataB/iLockB   : port B request signals and burst lock
//   oGntB/oRvalidB/oRdataB             : port B grant, read valid, read data
//   oRamWe/oRamAddr/oRamWdata          : RAM write enable, address, write data
//   iRamRdata                          : RAM read data (one cycle latency)
//   oConflictCount                     : saturating count of A/B conflict cycles
//   oStallA                            : A requesting but not granted (PC freeze)
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              iCpuClock,
  input  logic              iCpuReset,
  input  logic              iReqA,
  input  logic              iWeA,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [DATA_W-1:0] iWdataA,
  output logic              oGntA,
  output logic              oRvalidA,
  output logic [DATA_W-1:0] oRdataA,
  input  logic              iReqB,
  input  logic              iWeB,
  input  logic [ADDR_W-1:0] iAddrB,
  input  logic [DATA_W-1:0] iWdataB,
  input  logic              iLockB,
  output logic              oGntB,
  output logic              oRvalidB,
  output logic [DATA_W-1:0] oRdataB,
  output logic              oRamWe,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic [DATA_W-1:0] oRamWdata,
  input  logic [DATA_W-1:0] iRamRdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       oConflictCount,
`endif
  output logic              oStallA
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  arb_state_e        state_reg, state_next;
  logic              last_reg, last_next;
  logic [WAIT_W-1:0] wait_a_reg, wait_a_next;
  logic [1:0]        req, we_vec, rr_gnt, gnt;
  logic              wait_hit;

  assign req      = {iReqB, iReqA};
  assign we_vec   = {iWeB, iWeA};
  assign wait_hit = (wait_a_reg == WAIT_W'(MAX_WAIT));

  dmem_arb_rr_pick u_rr_pick (
    .req  (req),
    .last (last_reg),
    .gnt  (rr_gnt)
  );

  always_comb begin
    gnt         = 2'b00;
    state_next  = state_reg;
    last_next   = last_reg;
    wait_a_next = wait_a_reg;

    unique case (state_reg)
      RR: begin
        gnt = rr_gnt;
        if (rr_gnt[PORT_B] && iLockB) state_next = LOCK_B;
      end
      LOCK_B: begin
        // A starved long enough gets a single slot without leaving the lock.
        if (iReqA && wait_hit)  gnt = port_onehot(1'(PORT_A));
        else if (iReqB)         gnt = port_onehot(1'(PORT_B));
        else if (iReqA)         gnt = port_onehot(1'(PORT_A));
        if (!iLockB) state_next = RR;
      end
    endcase

    if (iCpuReset) gnt = 2'b00;

    if (gnt[PORT_A])      last_next = 1'(PORT_A);
    else if (gnt[PORT_B]) last_next = 1'(PORT_B);

    if (gnt[PORT_A])             wait_a_next = '0;
    else if (iReqA && !wait_hit) wait_a_next = wait_a_reg + WAIT_W'(1);
  end

  always_ff @(posedge iCpuClock) begin
    if (iCpuReset) begin
      state_reg  <= RR;
      last_reg   <= 1'(PORT_B);
      wait_a_reg <= '0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      wait_a_reg <= wait_a_next;
    end
  end

  assign oGntA   = gnt[PORT_A];
  assign oGntB   = gnt[PORT_B];
  assign oStallA = iReqA & ~gnt[PORT_A] & ~iCpuReset;

  always_comb begin
    oRamWe    = 1'b0;
    oRamAddr  = '0;
    oRamWdata = '0;
    if (gnt[PORT_A]) begin
      oRamWe    = iWeA;
      oRamAddr  = iAddrA;
      oRamWdata = iWdataA;
    end else if (gnt[PORT_B]) begin
      oRamWe    = iWeB;
      oRamAddr  = iAddrB;
      oRamWdata = iWdataB;
    end
  end

  // Read return: the RAM answers one cycle after the address, so the valid
  // flag is registered while the data is passed straight through and latched
  // for holding afterwards. Reset gates a pending return so it never appears.
  logic [1:0]        port_rvalid;
  logic [DATA_W-1:0] port_rdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    logic              pend_reg;
    logic [DATA_W-1:0] hold_reg;

    always_ff @(posedge iCpuClock) begin
      if (iCpuReset) begin
        pend_reg <= 1'b0;
        hold_reg <= '0;
      end else begin
        pend_reg <= gnt[gi] & ~we_vec[gi];
        if (pend_reg) hold_reg <= iRamRdata;
      end
    end

    assign port_rvalid[gi] = pend_reg & ~iCpuReset;
    assign port_rdata[gi]  = port_rvalid[gi] ? iRamRdata : hold_reg;
  end

  assign oRvalidA = port_rvalid[PORT_A];
  assign oRdataA  = port_rdata[PORT_A];
  assign oRvalidB = port_rvalid[PORT_B];
  assign oRdataB  = port_rdata[PORT_B];

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt_reg;

  always_ff @(posedge iCpuClock) begin
    if (iCpuReset) begin
      conflict_cnt_reg <= '0;
    end else if (iReqA && iReqB && (conflict_cnt_reg != 16'hFFFF)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
    end
  end

  assign oConflictCount = conflict_cnt_reg;
`endif

endmodule
